// File: rtl/wb_arbiter_2m_if.sv
// Wishbone pipelined bus bundle shared by the two masters and the slave port of wb_arbiter_2m.
// Forward signals (cyc..sel) flow master->slave; stall/ack/err/rdata flow slave->master.
interface wb_arbiter_2m_if #(
  parameter int unsigned AW = 30,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [SW-1:0] sel;
  logic          stall;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (output cyc, stb, we, addr, data, sel, input stall, ack, err, rdata);
  modport slave  (input cyc, stb, we, addr, data, sel, output stall, ack, err, rdata);
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with a per-cycle watchdog that aborts hung slave cycles.
// Ownership is held for the whole master cycle; one IDLE cycle always separates grants.
module wb_arbiter_2m #(
  parameter int unsigned AW      = 30,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  wb_arbiter_2m_if.slave   a,
  wb_arbiter_2m_if.slave   b,
  wb_arbiter_2m_if.master  wb,
  output logic [1:0]       o_grant,
  output logic             o_timeout
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {S_IDLE, S_OWN_A, S_OWN_B, S_ABORT} state_t;

  state_t        state;
  logic          last_b;
  logic [CW-1:0] wdog;
  logic          own_cyc;
  logic          abort_cyc;
  logic          timeout_hit;

  assign own_cyc     = (state == S_OWN_B) ? b.cyc : a.cyc;
  assign abort_cyc   = last_b ? b.cyc : a.cyc;
  assign timeout_hit = (wdog == CW'(TIMEOUT)) && !wb.ack && !wb.err;

  // State, last-owner, watchdog and timeout pulse; cyc drop takes priority over a same-cycle timeout.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      last_b    <= 1'b1;
      wdog      <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          wdog <= '0;
          if (a.cyc && (!b.cyc || last_b)) begin
            state  <= S_OWN_A;
            last_b <= 1'b0;
          end else if (b.cyc) begin
            state  <= S_OWN_B;
            last_b <= 1'b1;
          end
        end
        S_OWN_A, S_OWN_B: begin
          if (!own_cyc) begin
            state <= S_IDLE;
            wdog  <= '0;
          end else if (timeout_hit) begin
            state     <= S_ABORT;
            o_timeout <= 1'b1;
            wdog      <= '0;
          end else if (wb.ack || wb.err) begin
            wdog <= '0;
          end else begin
            wdog <= wdog + CW'(1);
          end
        end
        S_ABORT: begin
          wdog <= '0;
          if (!abort_cyc) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus steering: owner is wired straight through, everyone else is stalled and silenced.
  always_comb begin
    wb.cyc  = 1'b0;
    wb.stb  = 1'b0;
    wb.we   = 1'b0;
    wb.addr = AW'(0);
    wb.data = DW'(0);
    wb.sel  = SW'(0);
    a.stall = 1'b1;
    a.ack   = 1'b0;
    a.err   = 1'b0;
    b.stall = 1'b1;
    b.ack   = 1'b0;
    b.err   = 1'b0;
    a.rdata = wb.rdata;
    b.rdata = wb.rdata;
    o_grant = 2'b00;
    case (state)
      S_OWN_A: begin
        wb.cyc  = a.cyc;
        wb.stb  = a.stb;
        wb.we   = a.we;
        wb.addr = a.addr;
        wb.data = a.data;
        wb.sel  = a.sel;
        a.stall = wb.stall;
        a.ack   = wb.ack;
        a.err   = wb.err;
        o_grant = 2'b01;
      end
      S_OWN_B: begin
        wb.cyc  = b.cyc;
        wb.stb  = b.stb;
        wb.we   = b.we;
        wb.addr = b.addr;
        wb.data = b.data;
        wb.sel  = b.sel;
        b.stall = wb.stall;
        b.ack   = wb.ack;
        b.err   = wb.err;
        o_grant = 2'b10;
      end
      S_ABORT: begin
        // Synthetic error only in the first abort cycle, while the timeout pulse is high.
        if (last_b) b.err = o_timeout;
        else        a.err = o_timeout;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: vector table plus hand-built multi-cycle sequences.
module tb_wb_arbiter_2m;
  localparam int unsigned AW  = 30;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  // Expected-output encoding: {grant[1:0], wb_cyc, wb_stb, a_stall, a_ack, a_err, b_stall, b_ack, b_err, timeout}
  localparam logic [10:0] EX_IDLE = 11'b00_0_0_100_100_0;

  // Input encoding: {a_cyc, a_stb, b_cyc, b_stb, wb_stall, wb_ack, wb_err}
  typedef struct {
    logic [6:0]    in;
    logic [10:0]   ex;
    logic          chk_addr;
    logic [AW-1:0] addr;
    logic          we;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       tmo;

  wb_arbiter_2m_if #(.AW(AW), .DW(DW)) a_if ();
  wb_arbiter_2m_if #(.AW(AW), .DW(DW)) b_if ();
  wb_arbiter_2m_if #(.AW(AW), .DW(DW)) wb_if ();

  wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .a         (a_if),
    .b         (b_if),
    .wb        (wb_if),
    .o_grant   (grant),
    .o_timeout (tmo)
  );

  always #5 clk = ~clk;

  vec_t exp_q[$];
  vec_t tbl[13];
  int   nchk = 0;
  int   nerr = 0;
  int   vi   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s vec=%0d: got %0h expected %0h", name, vi, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] i, input logic [10:0] e);
    vec_t v;
    v.in = i; v.ex = e; v.chk_addr = 1'b0; v.addr = AW'(0); v.we = 1'b0;
    return v;
  endfunction

  function automatic vec_t mka(input logic [6:0] i, input logic [10:0] e, input logic [AW-1:0] ad);
    vec_t v;
    v = mk(i, e);
    v.chk_addr = 1'b1; v.addr = ad;
    return v;
  endfunction

  // Drive one cycle of stimulus just after the rising edge, check outputs on the falling edge.
  task automatic apply(input vec_t v);
    logic [DW-1:0] rd;
    vec_t e;
    a_if.cyc = v.in[6]; a_if.stb = v.in[5]; a_if.we = v.we; a_if.addr = v.addr;
    a_if.data = DW'(32'hA000_0000) | DW'(vi); a_if.sel = '1;
    b_if.cyc = v.in[4]; b_if.stb = v.in[3]; b_if.we = 1'b0; b_if.addr = '1;
    b_if.data = DW'(32'hB000_0000); b_if.sel = '0;
    wb_if.stall = v.in[2]; wb_if.ack = v.in[1]; wb_if.err = v.in[0];
    rd = DW'($urandom); wb_if.rdata = rd;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("grant",   32'(grant),       32'(e.ex[10:9]));
    chk("wb_cyc",  32'(wb_if.cyc),   32'(e.ex[8]));
    chk("wb_stb",  32'(wb_if.stb),   32'(e.ex[7]));
    chk("a_stall", 32'(a_if.stall),  32'(e.ex[6]));
    chk("a_ack",   32'(a_if.ack),    32'(e.ex[5]));
    chk("a_err",   32'(a_if.err),    32'(e.ex[4]));
    chk("b_stall", 32'(b_if.stall),  32'(e.ex[3]));
    chk("b_ack",   32'(b_if.ack),    32'(e.ex[2]));
    chk("b_err",   32'(b_if.err),    32'(e.ex[1]));
    chk("timeout", 32'(tmo),         32'(e.ex[0]));
    chk("a_rdata", 32'(a_if.rdata),  32'(rd));
    chk("b_rdata", 32'(b_if.rdata),  32'(rd));
    if (e.chk_addr) begin
      chk("wb_addr", 32'(wb_if.addr), 32'(e.addr));
      chk("wb_we",   32'(wb_if.we),   32'(e.we));
      chk("wb_data", 32'(wb_if.data), 32'(DW'(32'hA000_0000) | DW'(vi)));
    end
    vi++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Rows 0-12 start in IDLE right after reset (last owner = B).
    tbl[0]  = mk(7'b1010000, EX_IDLE);
    tbl[1]  = mk(7'b1110010, 11'b01_1_1_010_100_0);
    tbl[2]  = mk(7'b1010101, 11'b01_1_0_101_100_0);
    tbl[3]  = mk(7'b0010010, 11'b01_0_0_010_100_0);
    tbl[4]  = mk(7'b1010011, EX_IDLE);
    tbl[5]  = mk(7'b1011101, 11'b10_1_1_100_101_0);
    tbl[6]  = mk(7'b1010010, 11'b10_1_0_100_010_0);
    tbl[7]  = mk(7'b1000000, 11'b10_0_0_100_000_0);
    tbl[8]  = mk(7'b1000000, EX_IDLE);
    tbl[9]  = mk(7'b0010000, 11'b01_0_0_000_100_0);
    tbl[10] = mk(7'b1000000, EX_IDLE);
    tbl[11] = mk(7'b0000000, 11'b01_0_0_000_100_0);
    tbl[12] = mk(7'b0000000, EX_IDLE);

    a_if.cyc = 1'b1; a_if.stb = 1'b1; a_if.we = 1'b1; a_if.addr = '0; a_if.data = '0; a_if.sel = '1;
    b_if.cyc = 1'b1; b_if.stb = 1'b1; b_if.we = 1'b0; b_if.addr = '0; b_if.data = '0; b_if.sel = '1;
    wb_if.stall = 1'b0; wb_if.ack = 1'b1; wb_if.err = 1'b1; wb_if.rdata = '0;

    // Outputs forced idle while reset is held, regardless of requests and slave responses.
    #12;
    chk("rst_grant",   32'(grant),      32'd0);
    chk("rst_wb_cyc",  32'(wb_if.cyc),  32'd0);
    chk("rst_wb_stb",  32'(wb_if.stb),  32'd0);
    chk("rst_a_stall", 32'(a_if.stall), 32'd1);
    chk("rst_b_stall", 32'(b_if.stall), 32'd1);
    chk("rst_acks",    32'({a_if.ack, b_if.ack, a_if.err, b_if.err}), 32'd0);
    chk("rst_timeout", 32'(tmo),        32'd0);
    a_if.cyc = 1'b0; a_if.stb = 1'b0; b_if.cyc = 1'b0; b_if.stb = 1'b0;
    wb_if.ack = 1'b0; wb_if.err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) apply(tbl[i]);

    // B owns, A waits stalled, A granted two edges after B drops cyc (last owner now A).
    apply(mk(7'b0010000, EX_IDLE));
    for (int i = 0; i < 3; i++) apply(mk(7'b1010000, 11'b10_1_0_100_000_0));
    apply(mk(7'b1000000, 11'b10_0_0_100_000_0));
    apply(mk(7'b1000000, EX_IDLE));
    apply(mk(7'b1000000, 11'b01_1_0_000_100_0));
    apply(mk(7'b0000000, 11'b01_0_0_000_100_0));

    // A: four pipelined reads 0x10..0x13, slave stalls the second strobe once.
    apply(mk(7'b1100000, EX_IDLE));
    apply(mka(7'b1100000, 11'b01_1_1_000_100_0, AW'(30'h10)));
    apply(mka(7'b1100110, 11'b01_1_1_110_100_0, AW'(30'h11)));
    apply(mka(7'b1100000, 11'b01_1_1_000_100_0, AW'(30'h11)));
    apply(mka(7'b1100010, 11'b01_1_1_010_100_0, AW'(30'h12)));
    apply(mka(7'b1100010, 11'b01_1_1_010_100_0, AW'(30'h13)));
    apply(mk(7'b1000010, 11'b01_1_0_010_100_0));
    apply(mk(7'b0000000, 11'b01_0_0_000_100_0));

    // Slave never answers: TMO+1 owned cycles, then abort with a single err/timeout pulse.
    apply(mk(7'b1100000, EX_IDLE));
    for (int k = 0; k <= int'(TMO); k++)
      apply(mk({1'b1, 1'(k == 0), 5'b00000}, {3'b011, 1'(k == 0), 7'b000_100_0}));
    apply(mk(7'b1000000, 11'b00_0_0_101_100_1));
    apply(mk(7'b1000011, EX_IDLE));
    apply(mk(7'b0000000, EX_IDLE));

    // Ack restarts the watchdog; cyc dropping on the timeout cycle wins over the abort.
    apply(mk(7'b1100000, EX_IDLE));
    for (int k = 0; k <= 13; k++)
      apply(mk({1'(k != 13), 1'(k == 0), 3'b000, 1'(k == 4), 1'b0},
               {2'b01, 1'(k != 13), 1'(k == 0), 1'b0, 1'(k == 4), 5'b0_100_0}));
    apply(mk(7'b0000000, EX_IDLE));

    // Reset pulsed in the middle of an owned write cycle of A.
    begin
      vec_t v;
      v = mk(7'b1100000, EX_IDLE);
      v.we = 1'b1;
      apply(v);
    end
    a_if.cyc = 1'b1; a_if.stb = 1'b1; a_if.we = 1'b1; a_if.addr = AW'(30'h55);
    a_if.data = DW'(32'hCAFE_F00D);
    b_if.cyc = 1'b1; b_if.stb = 1'b0;
    wb_if.stall = 1'b0; wb_if.ack = 1'b0; wb_if.err = 1'b0;
    #2;
    chk("pre_rst_grant",  32'(grant),      32'd1);
    chk("pre_rst_wb_cyc", 32'(wb_if.cyc),  32'd1);
    chk("pre_rst_wb_we",  32'(wb_if.we),   32'd1);
    chk("pre_rst_wdata",  32'(wb_if.data), 32'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb_cyc",  32'(wb_if.cyc),  32'd0);
    chk("mid_rst_wb_stb",  32'(wb_if.stb),  32'd0);
    chk("mid_rst_grant",   32'(grant),      32'd0);
    chk("mid_rst_a_err",   32'(a_if.err),   32'd0);
    chk("mid_rst_a_stall", 32'(a_if.stall), 32'd1);
    chk("mid_rst_timeout", 32'(tmo),        32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Tie right after reset goes to A even though A was the last owner before it.
    apply(mk(7'b1010000, 11'b01_1_0_000_100_0));
    apply(mk(7'b0010000, 11'b01_0_0_000_100_0));
    apply(mk(7'b0000000, EX_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
